// File: rtl/adh_bus_mux.sv
// adh_bus_mux: one-hot ADH source selector with wired-AND conflict behaviour, registered copy and sticky conflict flag.
// Define ADH_HOLD_EN to make an idle bus (CNTL=000) keep its last driven value instead of IDLE_VAL.
module adh_bus_mux #(
    parameter int            WIDTH    = 8,
    parameter int            NSRC     = 3,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NSRC-1:0]  CNTL,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_Q,
    output logic             CONFLICT,
    output logic             CONF_STK
);
    logic [WIDTH-1:0] src [3];
    logic [2:0]       sel;
    logic [WIDTH-1:0] wired;
    logic [WIDTH-1:0] idle;

    assign src[0] = IN0;
    assign src[1] = IN1;
    assign src[2] = IN2;

    // Unknown select bits never count as selected
    always_comb begin
        sel   = '0;
        wired = '1;
        for (int i = 0; i < 3; i++) begin
            sel[i] = (CNTL[i] === 1'b1);
            wired  = sel[i] ? (wired & src[i]) : wired;
        end
    end

    assign CONFLICT = (sel & (sel - 3'd1)) != 3'd0;
    assign OUT      = (sel == 3'd0) ? idle : wired;

`ifdef ADH_HOLD_EN
    logic [WIDTH-1:0] held;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            held <= '0;
        else if (sel != 3'd0)
            held <= OUT;
    end

    assign idle = held;
`else
    assign idle = IDLE_VAL;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_Q    <= '0;
            CONF_STK <= 1'b0;
        end else begin
            OUT_Q    <= OUT;
            CONF_STK <= CONF_STK | CONFLICT;
        end
    end
endmodule

// File: tb/tb_adh_bus_mux.sv
// tb_adh_bus_mux: directed and randomized checks of adh_bus_mux against a behavioural bus model.
// Honours ADH_HOLD_EN the same way the design does.
module tb_adh_bus_mux;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] CNTL = '0;
    logic [7:0] IN0 = '0, IN1 = '0, IN2 = '0;
    logic [7:0] OUT, OUT_Q;
    logic       CONFLICT, CONF_STK;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] q_m    = '0;
    logic [7:0] held_m = '0;
    logic       stk_m  = 1'b0;

    adh_bus_mux dut (
        .CLK(CLK), .RST(RST), .CNTL(CNTL),
        .IN0(IN0), .IN1(IN1), .IN2(IN2),
        .OUT(OUT), .OUT_Q(OUT_Q), .CONFLICT(CONFLICT), .CONF_STK(CONF_STK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nsel(input logic [2:0] c);
        return int'(c[0]) + int'(c[1]) + int'(c[2]);
    endfunction

    // Bus value: every selected source pulls bits low; nothing selected leaves idle/held charge
    function automatic logic [7:0] bus(input logic [2:0] c, input logic [7:0] a, b, d, h);
        logic [7:0] srcs [3];
        logic [7:0] r;
        srcs = '{a, b, d};
        if (nsel(c) == 0) begin
`ifdef ADH_HOLD_EN
            return h;
`else
            return 8'h00;
`endif
        end
        r = 8'hFF;
        for (int k = 0; k < 3; k++)
            if (c[k]) r = r & srcs[k];
        return r;
    endfunction

    task automatic check_now(input string tag);
        chk({tag, ".out"}, OUT, bus(CNTL, IN0, IN1, IN2, held_m));
        chk({tag, ".conflict"}, {7'd0, CONFLICT}, {7'd0, nsel(CNTL) > 1});
        chk({tag, ".out_q"}, OUT_Q, q_m);
        chk({tag, ".conf_stk"}, {7'd0, CONF_STK}, {7'd0, stk_m});
    endtask

    task automatic apply(input string tag, input logic [2:0] c, input logic [7:0] a, b, d);
        logic [7:0] e;
        @(negedge CLK);
        CNTL = c; IN0 = a; IN1 = b; IN2 = d;
        #1;
        check_now(tag);
        e = bus(c, a, b, d, held_m);
        @(posedge CLK);
        q_m   = e;
        stk_m = stk_m | (nsel(c) > 1);
        if (c != 3'd0) held_m = e;
    endtask

    initial begin
        #2;
        chk("rst.out_q", OUT_Q, 8'h00);
        chk("rst.conf_stk", {7'd0, CONF_STK}, 8'h00);
        @(negedge CLK);
        RST = 1'b0;

        apply("seq0", 3'b000, 8'h01, 8'h02, 8'h03);
        apply("seq1", 3'b001, 8'h01, 8'h02, 8'h03);
        apply("seq2", 3'b000, 8'h01, 8'h02, 8'h03);
        apply("seq3", 3'b010, 8'h01, 8'h02, 8'h03);
        apply("seq4", 3'b000, 8'h01, 8'h02, 8'h03);
        apply("seq5", 3'b100, 8'h01, 8'h02, 8'h03);
        apply("seq6", 3'b000, 8'h01, 8'h02, 8'h03);

        apply("and2", 3'b011, 8'hF0, 8'h3C, 8'h00);
        chk("and2.const", OUT, 8'h30);
        apply("after_conf", 3'b001, 8'hF0, 8'h3C, 8'h00);
        chk("stk.const", {7'd0, CONF_STK}, 8'h01);

        apply("sel2", 3'b100, 8'h00, 8'h00, 8'hA5);
        apply("sel2b", 3'b100, 8'h00, 8'h00, 8'hA5);
        chk("outq.const", OUT_Q, 8'hA5);

        // Asynchronous reset between clock edges
        @(negedge CLK);
        #1 RST = 1'b1;
        q_m = 8'h00; stk_m = 1'b0; held_m = 8'h00;
        #1;
        chk("arst.out_q", OUT_Q, 8'h00);
        chk("arst.conf_stk", {7'd0, CONF_STK}, 8'h00);
        chk("arst.out", OUT, 8'hA5);
        CNTL = 3'b001; IN0 = 8'h5A;
        #1 chk("arst.follow", OUT, 8'h5A);
        CNTL = 3'b000;
        #1 chk("arst.idle", OUT, 8'h00);
        RST = 1'b0;

        apply("and3", 3'b111, 8'hFF, 8'h0F, 8'h33);
        chk("and3.const", OUT, 8'h03);

        for (int i = 0; i < 300; i++)
            apply("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom));
        @(negedge CLK);
        #1 check_now("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
